param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu_pkg.sv | 39 +++
 rtl/param_alu_mul.sv | 51 +++++
 rtl/param_alu.sv | 163 ++++++++++++++++
 tb/tb_param_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/param_alu_pkg.sv
// Shared definitions for param_alu: op codes, FR flag bit positions and the FSM state type.
// The MUL state exists only when ALU_MUL_EN is defined.
package param_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  localparam int FR_ZF = 3;
  localparam int FR_SF = 2;
  localparam int FR_OF = 1;
  localparam int FR_CF = 0;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2} alu_state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1} alu_state_t;
`endif

  function automatic logic [3:0] make_flags(input logic zf, input logic sf,
                                            input logic of, input logic cf);
    logic [3:0] f;
    f        = '0;
    f[FR_ZF] = zf;
    f[FR_SF] = sf;
    f[FR_OF] = of;
    f[FR_CF] = cf;
    return f;
  endfunction

endpackage

// File: rtl/param_alu_mul.sv
// Iterative shift-add unsigned multiplier: the first partial product is folded into the
// start edge, so product/done appear WIDTH-1 cycles after start.
module param_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier  <= b >> 1;
        cnt     <= CW'(WIDTH - 1);
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/param_alu.sv
// Registered ALU with load-enabled A/B/OP registers and a start/done handshake.
// Define ALU_MUL_EN to build in the iterative MUL op (otherwise op 1001 is illegal).
module param_alu
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       op,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       FR,
  output alu_state_t       dbg_state
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE; done pulses for
  // exactly one cycle as F/FR take their new value; busy covers the whole MUL run.

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of, alu_cf;
  logic [3:0]       alu_flg;
  logic             accept;

  assign sum_ext   = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = a_q - b_q;
  assign shamt     = b_q[SHW-1:0];
  assign accept    = (state == S_IDLE) && start;
  assign dbg_state = state;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_cf  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_cf  = sum_ext[WIDTH];
        alu_of  = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_cf  = a_q < b_q;
        alu_of  = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_SLL:  alu_res = a_q << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      default: alu_res = '0;
    endcase
  end

  assign alu_flg = make_flags(alu_res == '0, alu_res[MSB], alu_of, alu_cf);

`ifdef ALU_MUL_EN
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_flg;

  assign mul_start = accept && (op_q == OP_MUL);
  assign busy      = (state == S_MUL);
  assign mul_flg   = make_flags(mul_prod[MSB:0] == '0, mul_prod[MSB],
                                |mul_prod[2*WIDTH-1:WIDTH], 1'b0);

  param_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_EXEC;
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) state_nxt = S_MUL;
`endif
        end
      end
      S_EXEC: state_nxt = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL: if (!mul_busy) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result is snapshotted on the accepting edge so loads on that same edge cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      flg_q <= '0;
      F     <= '0;
      FR    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (ld_a)  a_q  <= din;
        if (ld_b)  b_q  <= din;
        if (ld_op) op_q <= op;
      end
      if (accept) begin
        res_q <= alu_res;
        flg_q <= alu_flg;
      end
      if (state == S_EXEC) begin
        F    <= res_q;
        FR   <= flg_q;
        done <= 1'b1;
      end
`ifdef ALU_MUL_EN
      if ((state == S_MUL) && mul_done) begin
        F    <= mul_prod[MSB:0];
        FR   <= mul_flg;
        done <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Directed-vector bench for param_alu (WIDTH=32): a driver pushes expected {F,FR} into a
// queue at each start, and a negedge monitor pops and compares on every done pulse.
module tb_param_alu;
  import param_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic [3:0]   op = '0;
  logic         ld_a = 1'b0, ld_b = 1'b0, ld_op = 1'b0, start = 1'b0;
  logic         busy, done;
  logic [W-1:0] F;
  logic [3:0]   FR;
  alu_state_t   dbg_state;

  logic [W+3:0] exp_q[$];
  logic [W+3:0] mon_e;
  int           n_cmp = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  param_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .op        (op),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .ld_op     (ld_op),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .F         (F),
    .FR        (FR),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("F", F, mon_e[W+3:4]);
        check("FR", FR, mon_e[3:0]);
      end
    end
  end

  // Counts negedges until done, checks latency, busy cycle count and one-cycle done.
  // With poke set, a start and an ld_a are injected mid-run; both must be ignored.
  task automatic fire_and_wait(input int lat, input bit poke);
    int n, busy_cnt;
    bit seen;
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && n < lat + 8) begin
      @(negedge clk);
      start = 1'b0; ld_a = 1'b0;
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      if (poke && n == 5) begin
        start = 1'b1; ld_a = 1'b1; din = 32'h3;
      end
    end
    start = 1'b0; ld_a = 1'b0;
    check("latency", seen ? 64'(n) : 64'hFFFF, 64'(lat));
    check("busy_cycles", 64'(busy_cnt), (lat > 2) ? 64'(W) : 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o,
                        input logic [W-1:0] ef, input logic [3:0] efr, input int lat);
    @(negedge clk); din = a; ld_a = 1'b1; op = o; ld_op = 1'b1;
    @(negedge clk); ld_a = 1'b0; ld_op = 1'b0; din = b; ld_b = 1'b1;
    @(negedge clk); ld_b = 1'b0; start = 1'b1; exp_q.push_back({ef, efr});
    fire_and_wait(lat, 1'b0);
  endtask

  task automatic start_only(input logic [W-1:0] ef, input logic [3:0] efr, input int lat,
                            input bit poke);
    @(negedge clk); start = 1'b1; exp_q.push_back({ef, efr});
    fire_and_wait(lat, poke);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_F"}, F, 64'd0);
    check({tag, "_FR"}, FR, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, S_IDLE});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    run_op(32'h0A, 32'h14, OP_ADD, 32'h1E, 4'b0000, 2);
    run_op(32'h0A, 32'h14, OP_SUB, 32'hFFFFFFF6, 4'b0101, 2);
    run_op(32'h19, 32'h19, OP_SUB, 32'h0, 4'b1000, 2);
    run_op(32'hFFFFFFF6, 32'h5, OP_SLT, 32'h1, 4'b0000, 2);
    run_op(32'hFFFFFFF6, 32'h5, OP_SLTU, 32'h0, 4'b1000, 2);
    run_op(32'h1, 32'h24, OP_SLL, 32'h10, 4'b0000, 2);
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, OP_XOR, 32'hFF00FF00, 4'b0100, 2);
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, OP_OR, 32'hFFF0FFF0, 4'b0100, 2);
    run_op(32'hF0F0F0F0, 32'h0FF00FF0, OP_AND, 32'h00F000F0, 4'b0000, 2);
    run_op(32'h80000000, 32'hFFFFFF24, OP_SRA, 32'hF8000000, 4'b0100, 2);
    run_op(32'h80000000, 32'hFFFFFF24, OP_SRL, 32'h08000000, 4'b0000, 2);
    run_op(32'h7FFFFFFF, 32'h1, OP_ADD, 32'h80000000, 4'b0110, 2);

    // F/FR hold between done pulses.
    repeat (4) @(negedge clk);
    check("hold_F", F, 64'h80000000);
    check("hold_FR", FR, 64'h6);

    run_op(32'h5, 32'h6, 4'b1111, 32'h0, 4'b1000, 2);
`ifndef ALU_MUL_EN
    run_op(32'h7, 32'h6, OP_MUL, 32'h0, 4'b1000, 2);
`endif

    // Loads on the accepting edge must not affect that operation.
    run_op(32'h1, 32'h2, OP_ADD, 32'h3, 4'b0000, 2);
    @(negedge clk); start = 1'b1; ld_a = 1'b1; din = 32'd100; exp_q.push_back({32'h3, 4'b0000});
    fire_and_wait(2, 1'b0);
    start_only(32'h66, 4'b0000, 2, 1'b0);

    // Asynchronous reset between clock edges clears outputs and registers.
    run_op(32'h7FFFFFFF, 32'h1, OP_ADD, 32'h80000000, 4'b0110, 2);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check_reset_outputs("async_reset");
    @(negedge clk); rst_n = 1'b1;
    start_only(32'h0, 4'b1000, 2, 1'b0);

`ifdef ALU_MUL_EN
    run_op(32'h10000, 32'h10000, OP_MUL, 32'h0, 4'b1010, W + 1);
    start_only(32'h0, 4'b1010, W + 1, 1'b1);
    start_only(32'h0, 4'b1010, W + 1, 1'b0);
    run_op(32'h7, 32'h6, OP_MUL, 32'h2A, 4'b0000, W + 1);

    // Abort a MUL partway through with reset; no done may follow.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("mul_busy_mid", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0; #1;
    check_reset_outputs("mul_abort");
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    run_op(32'h0A, 32'h14, OP_ADD, 32'h1E, 4'b0000, 2);
    run_op(32'h3, 32'h5, OP_MUL, 32'hF, 4'b0000, W + 1);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
